// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame width and bit-period helper.
// The transmitter and receiver both use baud_end_calc so their bit periods agree.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 3'd0;
    localparam uart_state_t ST_START = 3'd1;
    localparam uart_state_t ST_DATA  = 3'd2;
    localparam uart_state_t ST_STOP  = 3'd3;
    localparam uart_state_t ST_BREAK = 3'd4;

    function automatic int unsigned baud_end_calc(input int unsigned clk_freq,
                                                  input int unsigned baud_rate);
        return clk_freq / baud_rate - 1;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchroniser for a single asynchronous input; resets to 1 so an idle-high
// line shows no spurious edge when reset is released.
module uart_sync #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[N-2:0], d};
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, finds the start edge, samples each bit at its
// centre and strobes rx_valid per good byte or frame_err per bad stop bit.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | timing to mid start bit to reject glitches
// DATA  | sampling 8 data bits, LSB first
// STOP  | sampling the stop bit
// BREAK | stop bit was low; waiting for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       sys_clk_100M,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned BAUD_END_I = baud_end_calc(CLK_FREQ, BAUD_RATE);
    localparam logic [15:0] BAUD_END   = BAUD_END_I[15:0];
    localparam logic [15:0] BAUD_MID   = BAUD_END / 16'd2;

    logic                 rx_s2;
    logic                 rx_s3;
    uart_state_t          state, state_nxt;
    logic [15:0]          baud_cnt, baud_nxt;
    logic [3:0]           bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shift_q, shift_nxt;
    logic [7:0]           data_nxt;
    logic                 valid_nxt;
    logic                 ferr_nxt;

    uart_sync #(.N(2)) u_sync (
        .clk (sys_clk_100M),
        .rst (rst),
        .d   (rx),
        .q   (rx_s2)
    );

    always_ff @(posedge sys_clk_100M or posedge rst) begin
        if (rst) begin
            rx_s3 <= 1'b1;
        end else begin
            rx_s3 <= rx_s2;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_q;
        data_nxt  = rx_data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                baud_nxt = 16'd0;
                if (!rx_s2 && rx_s3) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (baud_cnt == BAUD_MID) begin
                    baud_nxt = 16'd0;
                    if (rx_s2) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        bit_nxt   = 4'd0;
                        state_nxt = ST_DATA;
                    end
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_cnt == BAUD_END) begin
                    baud_nxt                 = 16'd0;
                    shift_nxt[bit_cnt[2:0]]  = rx_s2;
                    if (bit_cnt == 4'(DATA_BITS - 1)) begin
                        state_nxt = ST_STOP;
                    end else begin
                        bit_nxt = bit_cnt + 4'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_cnt == BAUD_END) begin
                    baud_nxt = 16'd0;
                    // Leaving at mid stop bit leaves half a bit to catch the next start edge.
                    if (rx_s2) begin
                        data_nxt  = shift_q;
                        valid_nxt = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = ST_BREAK;
                    end
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            ST_BREAK: begin
                baud_nxt = 16'd0;
                if (rx_s2) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                baud_nxt  = 16'd0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_100M or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            baud_cnt  <= 16'd0;
            bit_cnt   <= 4'd0;
            shift_q   <= '0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            shift_q   <= shift_nxt;
            rx_data   <= data_nxt;
            rx_valid  <= valid_nxt;
            frame_err <= ferr_nxt;
            rx_busy   <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit; a negedge monitor counts strobes
// and collects received bytes for comparison against the bytes the bench sends.
module tb_uart_rx;

    localparam int CLK_NS = 10;
    localparam int BIT_NS = 100;

    logic       sys_clk_100M = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int n_chk = 0;
    int n_err = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_both = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_rx #(
        .CLK_FREQ  (1_000_000),
        .BAUD_RATE (100_000)
    ) dut (
        .sys_clk_100M (sys_clk_100M),
        .rst          (rst),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .frame_err    (frame_err),
        .rx_busy      (rx_busy)
    );

    always #(CLK_NS / 2) sys_clk_100M = ~sys_clk_100M;

    always @(negedge sys_clk_100M) begin
        if (!rst) begin
            if (rx_valid) begin
                n_valid++;
                got_q.push_back(rx_data);
            end
            if (frame_err) n_ferr++;
            if (rx_valid && frame_err) n_both++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop_bit, input int bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            #(bit_ns);
        end
        rx = stop_bit;
        #(bit_ns);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge sys_clk_100M);
        #2;
    endtask

    task automatic check_rx_queue(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int base_v;
        int base_f;
        logic [7:0] b;

        #3;
        chk("rst_data", rx_data, 8'h00);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_busy", rx_busy, 1'b0);
        wait_clks(3);
        rst = 1'b0;
        wait_clks(5);

        // single frame 0x55
        exp_q.push_back(8'h55);
        fork
            send_byte(8'h55, 1'b1, BIT_NS);
            begin
                #(5 * BIT_NS);
                chk("busy_mid_frame", rx_busy, 1'b1);
            end
        join
        wait_clks(20);
        chk("f55_valid_cnt", n_valid, 1);
        chk("f55_data", rx_data, 8'h55);
        chk("f55_ferr_cnt", n_ferr, 0);
        chk("f55_busy_low", rx_busy, 1'b0);
        check_rx_queue("f55");

        // back-to-back frames
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_byte(8'hA3, 1'b1, BIT_NS);
        send_byte(8'h00, 1'b1, BIT_NS);
        send_byte(8'hFF, 1'b1, BIT_NS);
        wait_clks(20);
        chk("b2b_valid_cnt", n_valid, 4);
        check_rx_queue("b2b");

        // 3-cycle glitch on idle line
        base_v = n_valid;
        rx = 1'b0;
        repeat (3) @(posedge sys_clk_100M);
        rx = 1'b1;
        @(negedge sys_clk_100M);
        chk("glitch_busy_start", rx_busy, 1'b1);
        wait_clks(20);
        chk("glitch_busy_end", rx_busy, 1'b0);
        chk("glitch_valid", n_valid, base_v);
        chk("glitch_ferr", n_ferr, 0);
        chk("glitch_data", rx_data, 8'hFF);

        // bad stop bit followed by a long break
        base_v = n_valid;
        send_byte(8'h3C, 1'b0, BIT_NS);
        #(20 * BIT_NS);
        chk("break_busy_hold", rx_busy, 1'b1);
        rx = 1'b1;
        wait_clks(10);
        chk("break_busy_end", rx_busy, 1'b0);
        chk("break_ferr_cnt", n_ferr, 1);
        chk("break_valid", n_valid, base_v);
        chk("break_data", rx_data, 8'hFF);

        // reset in the middle of 0x81, bit 4
        base_v = n_valid;
        b = 8'h81;
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            #(BIT_NS);
        end
        rx = b[4];
        #(BIT_NS / 2);
        rst = 1'b1;
        #1;
        chk("midrst_data", rx_data, 8'h00);
        chk("midrst_valid", rx_valid, 1'b0);
        chk("midrst_ferr", frame_err, 1'b0);
        chk("midrst_busy", rx_busy, 1'b0);
        rx = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(5);
        chk("midrst_no_strobe", n_valid, base_v);
        exp_q.push_back(8'h7E);
        send_byte(8'h7E, 1'b1, BIT_NS);
        wait_clks(20);
        chk("post_rst_data", rx_data, 8'h7E);
        check_rx_queue("post_rst");

        // skewed line-rate stream of random bytes
        base_f = n_ferr;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_byte(b, 1'b1, (i % 2 == 0) ? 102 : 98);
        end
        wait_clks(20);
        chk("loop_ferr", n_ferr, base_f);
        check_rx_queue("loop");

        chk("valid_ferr_overlap", n_both, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
